// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
// Only the read-data register is reset; the array keeps its contents across reset.
module sync_fifo_mem #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PTR_ADDR = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                clr_n_i,
  input  logic                wr_en_i,
  input  logic [PTR_ADDR-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                rd_en_i,
  input  logic [PTR_ADDR-1:0] rd_addr_i,
  output logic [WIDTH-1:0]    rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wdata_i;
    end
  end

  // Holds the last word read when no read is accepted.
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_rdata <= '0;
    end else if (rd_en_i) begin
      r_rdata <= r_mem[rd_addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary pointers with wrap-toggle flags, registered overflow/underflow pulses.
// Storage and the registered read port live in sync_fifo_mem.
module sync_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PTR_ADDR = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             wr_error_o,
  output logic             rd_error_o
);

  localparam logic [PTR_ADDR-1:0] LastAddr = PTR_ADDR'(DEPTH - 1);

  logic [PTR_ADDR-1:0] r_wr_ptr, r_rd_ptr;
  logic                r_wr_toggle, r_rd_toggle;
  logic                r_wr_error, r_rd_error;
  logic                w_same_ptr, w_full, w_empty;
  logic                w_wr_accept, w_rd_accept;

  assign w_same_ptr  = (r_wr_ptr == r_rd_ptr);
  assign w_empty     = w_same_ptr && (r_wr_toggle == r_rd_toggle);
  assign w_full      = w_same_ptr && (r_wr_toggle != r_rd_toggle);
  // Both requests are judged against the pre-edge flags.
  assign w_wr_accept = wr_en_i && !w_full;
  assign w_rd_accept = rd_en_i && !w_empty;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_wr_ptr    <= '0;
      r_wr_toggle <= 1'b0;
    end else if (w_wr_accept) begin
      if (r_wr_ptr == LastAddr) begin
        r_wr_ptr    <= '0;
        r_wr_toggle <= ~r_wr_toggle;
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_rd_ptr    <= '0;
      r_rd_toggle <= 1'b0;
    end else if (w_rd_accept) begin
      if (r_rd_ptr == LastAddr) begin
        r_rd_ptr    <= '0;
        r_rd_toggle <= ~r_rd_toggle;
      end else begin
        r_rd_ptr <= r_rd_ptr + PTR_ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      r_wr_error <= 1'b0;
      r_rd_error <= 1'b0;
    end else begin
      r_wr_error <= wr_en_i & w_full;
      r_rd_error <= rd_en_i & w_empty;
    end
  end

  sync_fifo_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .PTR_ADDR (PTR_ADDR)
  ) u_mem (
    .clk_i     (clk_i),
    .clr_n_i   (clr_n_i),
    .wr_en_i   (w_wr_accept),
    .wr_addr_i (r_wr_ptr),
    .wdata_i   (wdata_i),
    .rd_en_i   (w_rd_accept),
    .rd_addr_i (r_rd_ptr),
    .rdata_o   (rdata_o)
  );

  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign wr_error_o = r_wr_error;
  assign rd_error_o = r_rd_error;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_sync_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             full, empty, wr_err, rd_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i      (clk),
    .clr_n_i    (clr_n),
    .wr_en_i    (wr_en),
    .wdata_i    (wdata),
    .rd_en_i    (rd_en),
    .rdata_o    (rdata),
    .full_o     (full),
    .empty_o    (empty),
    .wr_error_o (wr_err),
    .rd_error_o (rd_err)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored words plus the expected registered outputs.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_wr_err, m_rd_err;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q.delete();
      m_rdata  <= '0;
      m_wr_err <= 1'b0;
      m_rd_err <= 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_wr_err <= wr_en && was_full;
      m_rd_err <= rd_en && was_empty;
      if (rd_en && !was_empty) m_rdata <= q.pop_front();
      if (wr_en && !was_full) q.push_back(wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_empty", 32'(empty), 32'(q.size() == 0));
      check("model_full", 32'(full), 32'(q.size() == DEPTH));
      check("model_rdata", 32'(rdata), 32'(m_rdata));
      check("model_wr_err", 32'(wr_err), 32'(m_wr_err));
      check("model_rd_err", 32'(rd_err), 32'(m_rd_err));
    end
  end

  task automatic drive(input logic w, input logic r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wdata = d;
  endtask

  // Applies the drive, waits past the next rising edge, leaves inputs idle afterwards.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    drive(w, r, d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [WIDTH-1:0] last;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_errs", {30'd0, wr_err, rd_err}, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // 16 writes of 01..10 fill the FIFO
    cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, WIDTH'(i));
      cnt += int'(wr_err);
    end
    check("t1_full", 32'(full), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    check("t1_no_err", 32'(cnt), 32'd0);

    // drain in order, 1-cycle latency
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, '0);
      check("t2_rdata", 32'(rdata), 32'(i));
    end
    check("t2_empty", 32'(empty), 32'd1);

    // 19 writes: last three rejected
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b0, WIDTH'(8'h20 + i));
      cnt += int'(wr_err);
    end
    step(1'b0, 1'b0, '0);
    cnt += int'(wr_err);
    check("t3_wr_err_pulses", 32'(cnt), 32'd3);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      check("t3_rdata", 32'(rdata), 32'(8'h20 + i));
    end

    // 16 writes then 19 reads: three underflow pulses, rdata holds 16th word
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i));
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b1, '0);
      cnt += int'(rd_err);
    end
    step(1'b0, 1'b0, '0);
    cnt += int'(rd_err);
    check("t4_rd_err_pulses", 32'(cnt), 32'd3);
    check("t4_rdata_hold", 32'(rdata), 32'h4f);
    check("t4_empty", 32'(empty), 32'd1);

    // 8 stored, concurrent traffic across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, WIDTH'(8'h60 + i));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, WIDTH'(8'h68 + i));
      check("t5_rdata", 32'(rdata), 32'(8'h60 + i));
      cnt += int'(wr_err) + int'(rd_err) + int'(full) + int'(empty);
    end
    check("t5_no_err_no_flag", 32'(cnt), 32'd0);

    // asynchronous clear with 5 stored
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'h80 + i));
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("t6_async_empty", 32'(empty), 32'd1);
    check("t6_async_full", 32'(full), 32'd0);
    check("t6_async_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, '0);
    check("t6_new_data", 32'(rdata), 32'hA5);
    check("t6_empty_after", 32'(empty), 32'd1);

    // randomized traffic, varying write/read bias per block
    for (int b = 0; b < 20; b++) begin
      int unsigned wp, rp;
      wp = $urandom_range(90, 10);
      rp = $urandom_range(90, 10);
      for (int i = 0; i < 100; i++) begin
        drive(($urandom_range(99) < wp), ($urandom_range(99) < rp), WIDTH'($urandom));
      end
      if (b == 10) do_reset();
    end
    drive(1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
